// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: partial-sum width, default FIFO depth and a
// constant clog2 helper used to size pointers and counters.
package cnn_pkg;

  localparam int PSUM_WIDTH      = 16;
  localparam int PSUM_FIFO_DEPTH = 32;

  typedef logic signed [PSUM_WIDTH-1:0] psum_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/psum_fifo_mem.sv
// Partial-sum storage: DEPTH x DATA_WIDTH register array with one synchronous
// write port and one asynchronous read port. No reset, so it maps to distributed RAM.
module psum_fifo_mem
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = PSUM_WIDTH,
  parameter int DEPTH      = PSUM_FIFO_DEPTH,
  parameter int ADDR_WIDTH = clog2(PSUM_FIFO_DEPTH)
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic signed [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]        raddr,
  output logic signed [DATA_WIDTH-1:0] rdata
);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/psum_fifo.sv
// Show-ahead partial-sum FIFO between PE array rows; reads 0 when empty.
// Optional sticky overflow/underflow flags are built only when PSUM_FIFO_ERR_EN is defined.
module psum_fifo
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = PSUM_WIDTH,
  parameter int DEPTH      = PSUM_FIFO_DEPTH,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                         PSUM_FIFO_Clk,
  input  logic                         PSUM_FIFO_Reset,
  input  logic                         PSUM_FIFO_Flush,
  input  logic                         PSUM_FIFO_Push,
  input  logic signed [DATA_WIDTH-1:0] PSUM_FIFO_Data_In,
  input  logic                         PSUM_FIFO_Pop,
  output logic signed [DATA_WIDTH-1:0] PSUM_FIFO_Data_Out,
  output logic                         PSUM_FIFO_Empty,
  output logic                         PSUM_FIFO_Full,
  output logic [CNT_WIDTH-1:0]         PSUM_FIFO_Count,
  output logic                         PSUM_FIFO_Ovf,
  output logic                         PSUM_FIFO_Udf
);

  localparam int PTR_WIDTH = clog2(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_DEPTH = CNT_WIDTH'(DEPTH);

  logic [PTR_WIDTH-1:0]         wr_ptr;
  logic [PTR_WIDTH-1:0]         rd_ptr;
  logic [CNT_WIDTH-1:0]         count;
  logic                         wr_ok;
  logic                         rd_ok;
  logic                         mem_we;
  logic signed [DATA_WIDTH-1:0] head;

  assign PSUM_FIFO_Empty = (count == '0);
  assign PSUM_FIFO_Full  = (count == CNT_DEPTH);
  assign PSUM_FIFO_Count = count;

  // A full FIFO still takes a push when the head is consumed in the same cycle.
  assign wr_ok  = PSUM_FIFO_Push & (~PSUM_FIFO_Full | PSUM_FIFO_Pop);
  assign rd_ok  = PSUM_FIFO_Pop & ~PSUM_FIFO_Empty;
  assign mem_we = wr_ok & ~PSUM_FIFO_Flush;

  always_ff @(posedge PSUM_FIFO_Clk or negedge PSUM_FIFO_Reset) begin
    if (!PSUM_FIFO_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (PSUM_FIFO_Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CNT_WIDTH'(wr_ok) - CNT_WIDTH'(rd_ok);
    end
  end

  psum_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk   (PSUM_FIFO_Clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (PSUM_FIFO_Data_In),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Empty reads as zero so the first row accumulates from nothing.
  assign PSUM_FIFO_Data_Out = PSUM_FIFO_Empty ? '0 : head;

`ifdef PSUM_FIFO_ERR_EN
  always_ff @(posedge PSUM_FIFO_Clk or negedge PSUM_FIFO_Reset) begin
    if (!PSUM_FIFO_Reset) begin
      PSUM_FIFO_Ovf <= 1'b0;
      PSUM_FIFO_Udf <= 1'b0;
    end else begin
      if (PSUM_FIFO_Push & PSUM_FIFO_Full & ~PSUM_FIFO_Pop) PSUM_FIFO_Ovf <= 1'b1;
      if (PSUM_FIFO_Pop & PSUM_FIFO_Empty)                  PSUM_FIFO_Udf <= 1'b1;
    end
  end
`else
  assign PSUM_FIFO_Ovf = 1'b0;
  assign PSUM_FIFO_Udf = 1'b0;
`endif

endmodule

// File: tb/tb_psum_fifo.sv
// Directed bench for psum_fifo at DEPTH=4: table of per-cycle vectors plus
// hand-written reset, flag and asynchronous-reset sequences.
module tb_psum_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

`ifdef PSUM_FIFO_ERR_EN
  localparam logic FLAG_EXP = 1'b1;
`else
  localparam logic FLAG_EXP = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic                 push;
  logic                 pop;
  logic signed [DW-1:0] din;
  logic signed [DW-1:0] dout;
  logic                 empty;
  logic                 full;
  logic [CW-1:0]        count;
  logic                 ovf;
  logic                 udf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic                 push;
    logic                 pop;
    logic                 flush;
    logic signed [DW-1:0] din;
    int                   exp_count;
    logic                 exp_empty;
    logic                 exp_full;
    logic signed [DW-1:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  psum_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .PSUM_FIFO_Clk      (clk),
    .PSUM_FIFO_Reset    (rst_n),
    .PSUM_FIFO_Flush    (flush),
    .PSUM_FIFO_Push     (push),
    .PSUM_FIFO_Data_In  (din),
    .PSUM_FIFO_Pop      (pop),
    .PSUM_FIFO_Data_Out (dout),
    .PSUM_FIFO_Empty    (empty),
    .PSUM_FIFO_Full     (full),
    .PSUM_FIFO_Count    (count),
    .PSUM_FIFO_Ovf      (ovf),
    .PSUM_FIFO_Udf      (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int idx, input int e_count,
                             input logic e_empty, input logic e_full,
                             input logic signed [DW-1:0] e_dout);
    check({tag, " count"}, idx, longint'(count), longint'(e_count));
    check({tag, " empty"}, idx, longint'(empty), longint'(e_empty));
    check({tag, " full"},  idx, longint'(full),  longint'(e_full));
    check({tag, " dout"},  idx, longint'(dout),  longint'(e_dout));
  endtask

  function automatic vec_t mk(input logic p, input logic q, input logic f,
                              input int d, input int c, input logic e,
                              input logic fu, input int o);
    vec_t v;
    v.push = p; v.pop = q; v.flush = f; v.din = DW'(d);
    v.exp_count = c; v.exp_empty = e; v.exp_full = fu; v.exp_dout = DW'(o);
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; din = '0;

    // fill order, then drain in order
    vecs.push_back(mk(1, 0, 0,   -5, 1, 0, 0,  -5));
    vecs.push_back(mk(1, 0, 0,    7, 2, 0, 0,  -5));
    vecs.push_back(mk(1, 0, 0,  300, 3, 0, 0,  -5));
    vecs.push_back(mk(1, 0, 0,   -1, 4, 0, 1,  -5));
    vecs.push_back(mk(0, 1, 0,    0, 3, 0, 0,   7));
    vecs.push_back(mk(0, 1, 0,    0, 2, 0, 0, 300));
    vecs.push_back(mk(0, 1, 0,    0, 1, 0, 0,  -1));
    vecs.push_back(mk(0, 1, 0,    0, 0, 1, 0,   0));
    // refill, then simultaneous push/pop while full across the wrap
    vecs.push_back(mk(1, 0, 0,   10, 1, 0, 0,  10));
    vecs.push_back(mk(1, 0, 0,   20, 2, 0, 0,  10));
    vecs.push_back(mk(1, 0, 0,   30, 3, 0, 0,  10));
    vecs.push_back(mk(1, 0, 0,   40, 4, 0, 1,  10));
    vecs.push_back(mk(1, 1, 0,   50, 4, 0, 1,  20));
    vecs.push_back(mk(1, 1, 0,   60, 4, 0, 1,  30));
    vecs.push_back(mk(1, 1, 0,   70, 4, 0, 1,  40));
    vecs.push_back(mk(1, 1, 0,   80, 4, 0, 1,  50));
    vecs.push_back(mk(1, 1, 0,   90, 4, 0, 1,  60));
    vecs.push_back(mk(1, 1, 0,  100, 4, 0, 1,  70));
    // push while full without pop is dropped
    vecs.push_back(mk(1, 0, 0,   99, 4, 0, 1,  70));
    vecs.push_back(mk(0, 1, 0,    0, 3, 0, 0,  80));
    vecs.push_back(mk(0, 1, 0,    0, 2, 0, 0,  90));
    vecs.push_back(mk(0, 1, 0,    0, 1, 0, 0, 100));
    vecs.push_back(mk(0, 1, 0,    0, 0, 1, 0,   0));
    // pop on empty ignored; push+pop on empty keeps only the push
    vecs.push_back(mk(0, 1, 0,    0, 0, 1, 0,   0));
    vecs.push_back(mk(1, 1, 0,   42, 1, 0, 0,  42));
    vecs.push_back(mk(1, 0, 0,    1, 2, 0, 0,  42));
    vecs.push_back(mk(1, 0, 0,    2, 3, 0, 0,  42));
    // flush beats a concurrent push
    vecs.push_back(mk(1, 0, 1,    5, 0, 1, 0,   0));
    vecs.push_back(mk(1, 0, 0,    8, 1, 0, 0,   8));
    vecs.push_back(mk(1, 0, 0, -32768, 2, 0, 0, 8));

    #12;
    check_state("reset", 0, 0, 1'b1, 1'b0, '0);
    check("reset ovf", 0, longint'(ovf), 0);
    check("reset udf", 0, longint'(udf), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      push = vecs[i].push; pop = vecs[i].pop; flush = vecs[i].flush; din = vecs[i].din;
      @(posedge clk); #1;
      check_state("vec", i, vecs[i].exp_count, vecs[i].exp_empty, vecs[i].exp_full, vecs[i].exp_dout);
    end
    push = 1'b0; pop = 1'b0; flush = 1'b0; din = '0;

    // flags are sticky through the flush
    check("ovf sticky", 0, longint'(ovf), longint'(FLAG_EXP));
    check("udf sticky", 0, longint'(udf), longint'(FLAG_EXP));

    // asynchronous reset mid-stream with Count=2, observed before the next edge
    #2 rst_n = 1'b0;
    #1;
    check_state("async rst", 0, 0, 1'b1, 1'b0, '0);
    check("async rst ovf", 0, longint'(ovf), 0);
    check("async rst udf", 0, longint'(udf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_state("post rst", 0, 0, 1'b1, 1'b0, '0);

    push = 1'b1; din = 16'sd1234;
    @(posedge clk); #1;
    push = 1'b0;
    check_state("post rst push", 0, 1, 1'b0, 1'b0, 16'sd1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
